// File: rtl/ncl_pipe_pkg.sv
// Shared types and constants for the NCL pipeline head arbiter.
package ncl_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_WAVE = 2'd1,
    NULL_WAVE = 2'd2
  } state_t;

  localparam logic NCL_DATA = 1'b1;
  localparam logic NCL_NULL = 1'b0;

  localparam int DEF_MAX_INFLIGHT   = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/ncl_sync.sv
// Parameterized-depth flop synchronizer for one asynchronous bit, sync active-low reset.
module ncl_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic init_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sff;

  always_ff @(posedge clk) begin
    if (!init_n) sff <= '0;
    else         sff <= {sff[DEPTH-2:0], d};
  end

  assign q = sff[DEPTH-1];

endmodule

// File: rtl/pipe_head_arbiter.sv
// Two-requester round-robin token arbiter driving the head of an NCL pipeline.
// Optional handshake watchdog enabled by defining PIPE_HEAD_ARBITER_TIMEOUT_EN.
module pipe_head_arbiter
  import ncl_pipe_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int MAX_INFLIGHT   = DEF_MAX_INFLIGHT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       a_out,
  input  logic       a_comp_in,
  input  logic       e_in,
  output logic       e_comp_out,
  output logic [2:0] inflight,
  output logic       busy,
  output logic       timeout
);

  localparam logic [2:0] MAXF = 3'(MAX_INFLIGHT);

  logic       acs, es;
  state_t     state, state_nxt;
  logic [1:0] gnt_nxt;
  logic       rr_ptr;
  logic       full, es_rise, inc, dec;

  ncl_sync #(.DEPTH(SYNC_STAGES)) u_sync_a (.clk(clk), .init_n(init_n), .d(a_comp_in), .q(acs));
  ncl_sync #(.DEPTH(SYNC_STAGES)) u_sync_e (.clk(clk), .init_n(init_n), .d(e_in),      .q(es));

  assign full    = (inflight >= MAXF);
  // e_comp_out is es delayed one clock, so it doubles as the edge-detect history.
  assign es_rise = es & ~e_comp_out;
  assign inc     = |gnt_nxt;
  assign dec     = es_rise;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = 2'b00;
    case (state)
      IDLE: if (|req && !full) begin
        state_nxt = DATA_WAVE;
        if (req == 2'b11) gnt_nxt = rr_ptr ? 2'b10 : 2'b01;
        else              gnt_nxt = req;
      end
      DATA_WAVE: if (acs)  state_nxt = NULL_WAVE;
      NULL_WAVE: if (!acs) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state      <= IDLE;
      a_out      <= NCL_NULL;
      grant      <= 2'b00;
      e_comp_out <= 1'b0;
      inflight   <= '0;
      rr_ptr     <= 1'b0;
    end else begin
      state      <= state_nxt;
      a_out      <= (state_nxt == DATA_WAVE) ? NCL_DATA : NCL_NULL;
      grant      <= gnt_nxt;
      e_comp_out <= es;
      // pointer names the requester preferred on the next tie
      if (inc) rr_ptr <= gnt_nxt[0];
      case ({inc, dec})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   if (inflight != '0) inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
    end
  end

`ifdef PIPE_HEAD_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;

  // count restarts at zero on every state entry; flag fires as it reaches the limit
  always_ff @(posedge clk) begin
    if (!init_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (state_nxt != state) begin
      wd_cnt  <= '0;
    end else if (busy && wd_cnt <= TLIM) begin
      wd_cnt  <= wd_cnt + 16'd1;
      if (wd_cnt == TLIM) timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_head_arbiter.sv
// Directed self-checking bench for pipe_head_arbiter with a 3-cycle head-stage model.
module tb_pipe_head_arbiter;

  logic       clk = 1'b0;
  logic       init_n;
  logic [1:0] req;
  logic [1:0] grant;
  logic       a_out, a_comp_in, e_in, e_comp_out, busy, timeout;
  logic [2:0] inflight;

  logic       comp_en, e_drv, tail_auto, e_tog;
  logic [2:0] ap = 3'b000;
  int         tcnt;
  logic [1:0] gq[$];
  int         checks = 0;
  int         errors = 0;
  logic       to_exp;

  always #5 clk = ~clk;

  pipe_head_arbiter #(.SYNC_STAGES(2), .MAX_INFLIGHT(2), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .init_n(init_n), .req(req), .grant(grant), .a_out(a_out),
    .a_comp_in(a_comp_in), .e_in(e_in), .e_comp_out(e_comp_out),
    .inflight(inflight), .busy(busy), .timeout(timeout)
  );

  // first pipeline stage: completion follows a_out three clocks later
  always @(posedge clk) ap <= {ap[1:0], a_out};
  assign a_comp_in = comp_en ? ap[2] : 1'b0;

  always @(posedge clk) begin
    if (!tail_auto) begin
      tcnt  <= 0;
      e_tog <= 1'b0;
    end else if (tcnt == 7) begin
      tcnt  <= 0;
      e_tog <= ~e_tog;
    end else begin
      tcnt  <= tcnt + 1;
    end
  end
  assign e_in = tail_auto ? e_tog : e_drv;

  always @(negedge clk) if (grant != 2'b00) gq.push_back(grant);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    init_n = 1'b0; req = 2'b00; e_drv = 1'b0; tail_auto = 1'b0; comp_en = 1'b1;
    step(4);
    init_n = 1'b1;
    gq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PIPE_HEAD_ARBITER_TIMEOUT_EN
    to_exp = 1'b1;
`else
    to_exp = 1'b0;
`endif
    // reset values
    init_n = 1'b0; req = 2'b00; e_drv = 1'b0; tail_auto = 1'b0; comp_en = 1'b1;
    step(4);
    chk("rst_a_out", 32'(a_out), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ecomp", 32'(e_comp_out), 0);
    chk("rst_timeout", 32'(timeout), 0);
    init_n = 1'b1;

    // single token: a_out rises with grant, falls 6 clocks later, IDLE 6 after that
    req = 2'b01;
    step(1);
    chk("s1_grant", 32'(grant), 32'h1);
    chk("s1_a_out_hi", 32'(a_out), 1);
    chk("s1_busy", 32'(busy), 1);
    chk("s1_inflight", 32'(inflight), 1);
    req = 2'b00;
    step(1);
    chk("s1_grant_pulse", 32'(grant), 0);
    step(4);
    chk("s1_a_out_hold", 32'(a_out), 1);
    step(1);
    chk("s1_a_out_null", 32'(a_out), 0);
    chk("s1_busy_null", 32'(busy), 1);
    step(5);
    chk("s1_busy_wait", 32'(busy), 1);
    step(1);
    chk("s1_idle", 32'(busy), 0);
    chk("s1_inflight_kept", 32'(inflight), 1);
    // tail edge: two sync flops, then decrement and e_comp_out together
    e_drv = 1'b1;
    step(2);
    chk("s1_tail_pre", 32'(inflight), 1);
    chk("s1_ecomp_pre", 32'(e_comp_out), 0);
    step(1);
    chk("s1_tail_dec", 32'(inflight), 0);
    chk("s1_ecomp", 32'(e_comp_out), 1);
    e_drv = 1'b0;

    // round-robin with both requesters held
    do_reset();
    tail_auto = 1'b1;
    req = 2'b11;
    step(120);
    req = 2'b00;
    tail_auto = 1'b0;
    chk("rr_count", 32'(gq.size() >= 4), 1);
    if (gq.size() >= 4) begin
      chk("rr_g0", 32'(gq[0]), 32'h1);
      chk("rr_g1", 32'(gq[1]), 32'h2);
      chk("rr_g2", 32'(gq[2]), 32'h1);
      chk("rr_g3", 32'(gq[3]), 32'h2);
    end

    // saturation: tail stuck low allows only MAX_INFLIGHT grants
    do_reset();
    req = 2'b01;
    step(60);
    chk("sat_grants", 32'(gq.size()), 2);
    chk("sat_inflight", 32'(inflight), 2);
    chk("sat_idle", 32'(busy), 0);
    e_drv = 1'b1;
    step(3);
    chk("sat_dec", 32'(inflight), 1);
    chk("sat_no_grant", 32'(gq.size()), 2);
    step(1);
    chk("sat_regrant", 32'(grant), 32'h1);
    chk("sat_refill", 32'(inflight), 2);
    req = 2'b00;

    // grant on the same edge as an es rising edge
    do_reset();
    req = 2'b01;
    step(1);
    req = 2'b00;
    step(20);
    chk("co_setup", 32'(inflight), 1);
    e_drv = 1'b1;
    step(2);
    req = 2'b01;
    step(1);
    chk("co_grant", 32'(grant), 32'h1);
    chk("co_inflight", 32'(inflight), 1);
    req = 2'b00;

    // reset while in DATA_WAVE
    do_reset();
    req = 2'b01;
    step(1);
    chk("mr_data", 32'(a_out), 1);
    step(1);
    init_n = 1'b0;
    step(1);
    chk("mr_a_out", 32'(a_out), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_inflight", 32'(inflight), 0);
    chk("mr_grant", 32'(grant), 0);
    req = 2'b00;
    step(1);
    init_n = 1'b1;
    step(3);
    chk("mr_no_replay", 32'(grant), 0);
    chk("mr_stay_idle", 32'(busy), 0);

    // watchdog: completion never arrives; count starts at 0 on entry, fires at 10
    do_reset();
    comp_en = 1'b0;
    req = 2'b01;
    step(1);
    req = 2'b00;
    chk("to_entry", 32'(timeout), 0);
    step(9);
    chk("to_early", 32'(timeout), 0);
    step(1);
    chk("to_fire", 32'(timeout), 32'(to_exp));
    step(10);
    chk("to_sticky", 32'(timeout), 32'(to_exp));
    chk("to_fsm_waits", 32'(a_out), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
